// File: rtl/rr_mux_arbiter4_pkg.sv
// Shared definitions for the four-requester round-robin mux arbiter:
// arbiter state encodings, requester count and small index helpers.
package rr_mux_arbiter4_pkg;

  localparam int unsigned NUM_REQ = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } pick_t;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4to1.sv
// Plain 4:1 single-bit multiplexer; the datapath shared by the arbiter's requesters.
module mux4to1 (
  input  logic       in0,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  input  logic [1:0] sel,
  output logic       out
);

  // select one data bit
  always_comb begin
    out = 1'b0;
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      2'd3:    out = in3;
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter4_chk.sv
// Property checker for rr_mux_arbiter4: grant vector shape and its agreement with busy/sel.
module rr_mux_arbiter4_chk
  import rr_mux_arbiter4_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  input logic [NUM_REQ-1:0] gnt,
  input logic [1:0]         sel,
  input logic               busy
);

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_busy_eq_gnt: assert property (@(posedge clk) disable iff (!rst_n) busy == (|gnt));
  a_sel_matches: assert property (@(posedge clk) disable iff (!rst_n) !busy || (gnt == onehot4(sel)));

endmodule

// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter sharing one mux4to1 among four requesters, with a
// bounded tenure per grant; out carries the granted requester's data bit.
module rr_mux_arbiter4
  import rr_mux_arbiter4_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               in0,
  input  logic               in1,
  input  logic               in2,
  input  logic               in3,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         sel,
  output logic               busy,
  output logic               out
);

  localparam logic [CNT_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? CNT_W'((1 << CNT_W) - 1)
                                                          : CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  // First asserted request scanning last+1, last+2, ... (mod 4); last itself is checked last.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] r, input logic [1:0] last);
    pick_t      p;
    logic [1:0] idx;
    p.valid = 1'b0;
    p.idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!p.valid && r[idx]) begin
        p.valid = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

  arb_state_e         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [1:0]         r_sel;
  logic               r_busy;
  logic [1:0]         r_last;
  logic [CNT_W-1:0]   r_hold_cnt;

  arb_state_e         w_state_nxt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [1:0]         w_sel_nxt;
  logic               w_busy_nxt;
  logic [1:0]         w_last_nxt;
  logic [CNT_W-1:0]   w_hold_nxt;
  logic [NUM_REQ-1:0] w_others;
  pick_t              w_pick_idle;
  pick_t              w_pick_hand;
  logic               w_expired;
  logic               w_take;
  logic [1:0]         w_take_idx;
  logic               w_mux_out;

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_IDLE;
      r_gnt      <= 4'b0000;
      r_sel      <= 2'd0;
      r_busy     <= 1'b0;
      r_last     <= 2'd3;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_sel      <= w_sel_nxt;
      r_busy     <= w_busy_nxt;
      r_last     <= w_last_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // next-state: idle pick, handoff, release or tenure count
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold_cnt;
    w_take      = 1'b0;
    w_take_idx  = 2'd0;
    // the current grantee is masked so a handoff never returns to it
    w_others    = req & ~onehot4(r_sel);
    w_pick_idle = rr_pick(req, r_last);
    w_pick_hand = rr_pick(w_others, r_sel);
    w_expired   = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_SAT);

    case (r_state)
      ARB_IDLE: begin
        if (w_pick_idle.valid) begin
          w_take     = 1'b1;
          w_take_idx = w_pick_idle.idx;
        end else begin
          w_take     = 1'b0;
        end
      end
      ARB_GRANT: begin
        if (w_pick_hand.valid && (!req[r_sel] || w_expired)) begin
          w_take     = 1'b1;
          w_take_idx = w_pick_hand.idx;
        end else if (!req[r_sel]) begin
          w_state_nxt = ARB_IDLE;
          w_gnt_nxt   = 4'b0000;
          w_busy_nxt  = 1'b0;
          w_hold_nxt  = '0;
        end else if (r_hold_cnt != HOLD_SAT) begin
          w_hold_nxt  = r_hold_cnt + HOLD_ONE;
        end else begin
          w_hold_nxt  = r_hold_cnt;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_gnt_nxt   = 4'b0000;
        w_busy_nxt  = 1'b0;
        w_hold_nxt  = '0;
      end
    endcase

    if (w_take) begin
      w_state_nxt = ARB_GRANT;
      w_gnt_nxt   = onehot4(w_take_idx);
      w_sel_nxt   = w_take_idx;
      w_busy_nxt  = 1'b1;
      w_hold_nxt  = HOLD_ONE;
      w_last_nxt  = w_take_idx;
    end else begin
      w_last_nxt  = r_last;
    end
  end

  mux4to1 u_mux (
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .sel (r_sel),
    .out (w_mux_out)
  );

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = r_busy;
  assign out  = r_busy ? w_mux_out : 1'b0;

endmodule
